multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore/Mealy FSM sequencing the multicycle MIPS datapath: fetch, decode, execute, writeback.
//  Successor to the fixed-latency controller. Adds the following:
//  - configurable memory wait states;
//  - I/J/branch/load/store support;
//  - a mult/div start/done handshake;
//  - a precise exception sequence (invalid opcode, overflow, divide-by-zero).
//  Sits between the instruction register (OPCode/Funct) and every datapath mux/write-enable.
// PARAMETERS
//  MEM_WAIT  2  idle cycles after any memory read before its data is valid (0 = none)
//  STATE_W   7  width of state code exported on Estado
// PORTS
//  Clock        in   1  system clock, all flops rising-edge
//  Reset        in   1  synchronous, active-high; sampled on rising Clock edge
//  OPCode       in   6  IR[31:26]
//  Funct        in   6  IR[5:0]
//  GT,EQ,LT     in   1  ALU compare flags (combinational, current cycle)
//  Overflow     in   1  ALU signed overflow (current cycle)
//  DivZero      in   1  divisor==0 from div unit
//  MDDone       in   1  mult/div result ready (level)
//  Estado       out  7  current state code (debug)
//  flag*        out  -  datapath controls, same names/widths as the existing control unit:
//                       PcWrite, IorD[2], MemCtrl, IrWrite, RegWrite, RegDist[3], RegA, RegB,
//                       ALUSrcA[2], ALUSrcB[3], ALUCtrl[3], PCSrc[3], EPC, ALUOut, MDR,
//                       MemReg[3], DivStart, MultStart, RegHighW, RegLowW, ExcpCtrl[2]
// BEHAVIOUR
//  - Reset=1 at an edge -> state RESET; any state, mid-instruction included.
//  - All flags are decoded from state; default is 0 for every flag not listed for a state.
//  - RESET: RegWrite=1, RegDist=100, MemReg=111 (init SP); goes to FETCH the cycle after Reset drops.
//  - FETCH: IorD=00, MemCtrl=0 (read), ALUSrcA=00, ALUSrcB=001, ALUCtrl=001 (PC+4).
//      Goes to MWAIT if MEM_WAIT>0, else IRLOAD.
//  - MWAIT: holds FETCH controls; a down-counter loaded with MEM_WAIT-1 leaves at 0 (exactly
//      MEM_WAIT cycles). The counter is shared by all memory states and reloads on every entry.
//  - IRLOAD: IrWrite=1, PcWrite=1, PCSrc=000.
//  - DECODE: RegA=RegB=1, ALUSrcA=00, ALUSrcB=011, ALUCtrl=001, ALUOut=1 (branch target). Dispatch:
//      - R-type 0x20/0x22/0x24 -> R_ALU (ALUCtrl 001/010/011)
//      - R-type 0x18 -> MD_START(mult); 0x1A -> MD_START(div)
//      - 0x08 addi -> I_ALU
//      - 0x23 lw, 0x2B sw -> ADDR
//      - 0x04 beq, 0x05 bne -> BRANCH
//      - 0x02 j -> JUMP
//      - any other OPCode or Funct -> EXC_EPC with code 00
//  - R_ALU/I_ALU: ALUSrcA=01; ALUSrcB=000 (R) / 010 (I); ALUOut=1.
//      Then WB, or EXC_EPC code 01 if Overflow=1 this cycle and op is add/sub/addi.
//  - WB: RegWrite=1, MemReg=000; RegDist=001 (rd) for R, 000 (rt) for I -> FETCH.
//  - ADDR: ALUSrcA=01, ALUSrcB=010, ALUCtrl=001, ALUOut=1.
//  - Load path: LDREQ (IorD=01, read) -> [MWAIT] -> LDMDR (MDR=1) -> LDWB (RegWrite=1,
//      RegDist=000, MemReg=001) -> FETCH.
//  - Store path: STORE (IorD=01, MemCtrl=1) for one cycle -> FETCH.
//  - BRANCH: ALUSrcA=01, ALUSrcB=000, ALUCtrl=010.
//      Mealy output PcWrite = beq ? EQ : ~EQ, with PCSrc=001. Always -> FETCH.
//  - JUMP: PcWrite=1, PCSrc=010 -> FETCH.
//  - MD_START: MultStart or DivStart=1 for exactly one cycle.
//      Div with DivZero=1 -> EXC_EPC code 10 (no Hi/Lo write); otherwise -> MD_WAIT.
//  - MD_WAIT: waits unbounded on MDDone. MDDone=1 -> MD_WB.
//      MDDone already high in the first MD_WAIT cycle is legal and is taken immediately.
//  - MD_WB: RegHighW=RegLowW=1 for one cycle -> FETCH.
//  - Exception sequence:
//      - EXC_EPC: ALUSrcA=00, ALUSrcB=001, ALUCtrl=010, EPC=1 (EPC<=PC-4); latch 2-bit code.
//      - EXC_RD: IorD=10, ExcpCtrl=code, read -> [MWAIT].
//      - EXC_LD: MDR=1.
//      - EXC_JMP: PcWrite=1, PCSrc=011 -> FETCH.
//  - MWAIT return target is held in a register written on entry to MWAIT: IRLOAD, LDMDR or EXC_LD.
//  - No state is unreachable. Any unused encoding -> RESET next cycle.
// STRUCTURE
//  - Package mc_ctrl_pkg holds:
//      - state localparams (7-bit codes);
//      - opcode and funct constants;
//      - flag encodings: IorD, ALUSrcB, PCSrc, MemReg, RegDist, ExcpCtrl codes.
//  - Single module. Three always blocks: state/counter/return/exc-code regs; next-state logic;
//    output decode.
//  - No sub-module; the wait counter is inline.
// TESTING
//  1. Reset=1 for 2 cycles, then 0 -> Estado=RESET with RegWrite=1, RegDist=100, MemReg=111;
//     then FETCH.
//  2. MEM_WAIT=2, add (OPCode 0, Funct 0x20) -> FETCH, MWAIT x2, IRLOAD, DECODE, R_ALU, WB
//     (RegWrite=1, RegDist=001).
//     Repeat with MEM_WAIT=0: 5 cycles total.
//  3. beq with EQ=1 -> PcWrite=1, PCSrc=001 in BRANCH. With EQ=0 -> PcWrite=0.
//     bne gives the inverse of both.
//  4. div with MDDone held low for 10 cycles -> stays in MD_WAIT with DivStart high only
//     1 cycle. MDDone=1 -> MD_WB with RegHighW=RegLowW=1.
//  5. Exceptions:
//     - OPCode 0x3F -> EXC_EPC (EPC=1), then ExcpCtrl=00 in EXC_RD;
//     - add with Overflow=1 -> code 01, no RegWrite;
//     - div with DivZero=1 -> code 10.
//  6. Reset asserted mid MD_WAIT and mid MWAIT -> RESET next edge; counter reloads on the
//     next fetch.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// State codes, instruction field constants and datapath control encodings shared by the
// multicycle MIPS controller.
package mc_ctrl_pkg;

    localparam int unsigned StateW = 7;

    typedef enum logic [StateW-1:0] {
        StReset   = 7'd0,
        StFetch   = 7'd1,
        StMwait   = 7'd2,
        StIrload  = 7'd3,
        StDecode  = 7'd4,
        StRAlu    = 7'd5,
        StIAlu    = 7'd6,
        StWb      = 7'd7,
        StAddr    = 7'd8,
        StLdreq   = 7'd9,
        StLdmdr   = 7'd10,
        StLdwb    = 7'd11,
        StStore   = 7'd12,
        StBranch  = 7'd13,
        StJump    = 7'd14,
        StMdStart = 7'd15,
        StMdWait  = 7'd16,
        StMdWb    = 7'd17,
        StExcEpc  = 7'd18,
        StExcRd   = 7'd19,
        StExcLd   = 7'd20,
        StExcJmp  = 7'd21
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00, OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2B;
    localparam logic [5:0] OpBeq = 6'h04, OpBne = 6'h05, OpJ = 6'h02;

    localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24;
    localparam logic [5:0] FnMult = 6'h18, FnDiv = 6'h1A;

    localparam logic [1:0] IordPc = 2'b00, IordAlu = 2'b01, IordExc = 2'b10;
    localparam logic [1:0] SrcAPc = 2'b00, SrcAReg = 2'b01;
    localparam logic [2:0] SrcBReg = 3'b000, SrcBFour = 3'b001, SrcBImm = 3'b010;
    localparam logic [2:0] SrcBImmSh = 3'b011;
    localparam logic [2:0] AluAdd = 3'b001, AluSub = 3'b010, AluAnd = 3'b011;
    localparam logic [2:0] PcSrcAlu = 3'b000, PcSrcAluOut = 3'b001, PcSrcJump = 3'b010;
    localparam logic [2:0] PcSrcExc = 3'b011;
    localparam logic [2:0] MemRegAlu = 3'b000, MemRegMdr = 3'b001, MemRegSp = 3'b111;
    localparam logic [2:0] RegDistRt = 3'b000, RegDistRd = 3'b001, RegDistSp = 3'b100;
    localparam logic [1:0] ExcOpcode = 2'b00, ExcOverflow = 2'b01, ExcDivZero = 2'b10;

    function automatic logic [2:0] r_alu_ctrl(input logic [5:0] funct);
        case (funct)
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/writeback with memory wait states,
// mult/div handshake and a precise exception sequence.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned STATE_W  = 7
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [5:0]         OPCode,
    input  logic [5:0]         Funct,
    input  logic               GT,
    input  logic               EQ,
    input  logic               LT,
    input  logic               Overflow,
    input  logic               DivZero,
    input  logic               MDDone,
    output logic [STATE_W-1:0] Estado,
    output logic               PcWrite,
    output logic [1:0]         IorD,
    output logic               MemCtrl,
    output logic               IrWrite,
    output logic               RegWrite,
    output logic [2:0]         RegDist,
    output logic               RegA,
    output logic               RegB,
    output logic [1:0]         ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [2:0]         ALUCtrl,
    output logic [2:0]         PCSrc,
    output logic               EPC,
    output logic               ALUOut,
    output logic               MDR,
    output logic [2:0]         MemReg,
    output logic               DivStart,
    output logic               MultStart,
    output logic               RegHighW,
    output logic               RegLowW,
    output logic [1:0]         ExcpCtrl
);

    localparam int unsigned CntW = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;

    state_e          state_q, state_d, ret_q, ret_d, mem_ret;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic            mem_req;
    logic            unused_cmp;

    assign unused_cmp = GT ^ LT;
    assign Estado     = STATE_W'(state_q);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StReset;
            ret_q   <= StIrload;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        mem_req = 1'b0;
        mem_ret = StIrload;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  begin mem_req = 1'b1; mem_ret = StIrload; end
            StMwait: begin
                if (cnt_q == '0) state_d = ret_q;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StIrload: state_d = StDecode;
            StDecode: begin
                state_d = StExcEpc;
                code_d  = ExcOpcode;
                case (OPCode)
                    OpRtype: begin
                        if (Funct == FnAdd || Funct == FnSub || Funct == FnAnd) begin
                            state_d = StRAlu;
                        end else if (Funct == FnMult || Funct == FnDiv) begin
                            state_d = StMdStart;
                        end
                    end
                    OpAddi:       state_d = StIAlu;
                    OpLw, OpSw:   state_d = StAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    default:      ;
                endcase
            end
            StRAlu: begin
                if (Overflow && (Funct == FnAdd || Funct == FnSub)) begin
                    state_d = StExcEpc;
                    code_d  = ExcOverflow;
                end else begin
                    state_d = StWb;
                end
            end
            StIAlu: begin
                if (Overflow) begin
                    state_d = StExcEpc;
                    code_d  = ExcOverflow;
                end else begin
                    state_d = StWb;
                end
            end
            StWb:     state_d = StFetch;
            StAddr:   state_d = (OPCode == OpLw) ? StLdreq : StStore;
            StLdreq:  begin mem_req = 1'b1; mem_ret = StLdmdr; end
            StLdmdr:  state_d = StLdwb;
            StLdwb:   state_d = StFetch;
            StStore:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StMdStart: begin
                if (Funct == FnDiv && DivZero) begin
                    state_d = StExcEpc;
                    code_d  = ExcDivZero;
                end else begin
                    state_d = StMdWait;
                end
            end
            StMdWait: if (MDDone) state_d = StMdWb;
            StMdWb:   state_d = StFetch;
            StExcEpc: state_d = StExcRd;
            StExcRd:  begin mem_req = 1'b1; mem_ret = StExcLd; end
            StExcLd:  state_d = StExcJmp;
            StExcJmp: state_d = StFetch;
            default:  state_d = StReset;
        endcase

        // Every memory read funnels through the shared wait counter, reloaded on each entry.
        if (mem_req) begin
            if (MEM_WAIT > 0) begin
                state_d = StMwait;
                ret_d   = mem_ret;
                cnt_d   = CntW'(MEM_WAIT - 1);
            end else begin
                state_d = mem_ret;
            end
        end
    end

    always_comb begin
        PcWrite   = 1'b0;
        IorD      = IordPc;
        MemCtrl   = 1'b0;
        IrWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDist   = RegDistRt;
        RegA      = 1'b0;
        RegB      = 1'b0;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBReg;
        ALUCtrl   = 3'b000;
        PCSrc     = PcSrcAlu;
        EPC       = 1'b0;
        ALUOut    = 1'b0;
        MDR       = 1'b0;
        MemReg    = MemRegAlu;
        DivStart  = 1'b0;
        MultStart = 1'b0;
        RegHighW  = 1'b0;
        RegLowW   = 1'b0;
        ExcpCtrl  = 2'b00;
        case (state_q)
            StReset: begin RegWrite = 1'b1; RegDist = RegDistSp; MemReg = MemRegSp; end
            StFetch: begin ALUSrcB = SrcBFour; ALUCtrl = AluAdd; end
            StMwait: begin
                // Keep the requesting state's address selection stable during the wait.
                case (ret_q)
                    StLdmdr: IorD = IordAlu;
                    StExcLd: begin IorD = IordExc; ExcpCtrl = code_q; end
                    default: begin ALUSrcB = SrcBFour; ALUCtrl = AluAdd; end
                endcase
            end
            StIrload: begin IrWrite = 1'b1; PcWrite = 1'b1; PCSrc = PcSrcAlu; end
            StDecode: begin
                RegA = 1'b1; RegB = 1'b1; ALUSrcB = SrcBImmSh; ALUCtrl = AluAdd; ALUOut = 1'b1;
            end
            StRAlu: begin
                ALUSrcA = SrcAReg; ALUSrcB = SrcBReg; ALUCtrl = r_alu_ctrl(Funct); ALUOut = 1'b1;
            end
            StIAlu, StAddr: begin
                ALUSrcA = SrcAReg; ALUSrcB = SrcBImm; ALUCtrl = AluAdd; ALUOut = 1'b1;
            end
            StWb: begin
                RegWrite = 1'b1;
                MemReg   = MemRegAlu;
                RegDist  = (OPCode == OpRtype) ? RegDistRd : RegDistRt;
            end
            StLdreq:  IorD = IordAlu;
            StLdmdr:  MDR = 1'b1;
            StLdwb:   begin RegWrite = 1'b1; RegDist = RegDistRt; MemReg = MemRegMdr; end
            StStore:  begin IorD = IordAlu; MemCtrl = 1'b1; end
            StBranch: begin
                ALUSrcA = SrcAReg; ALUSrcB = SrcBReg; ALUCtrl = AluSub; PCSrc = PcSrcAluOut;
                PcWrite = (OPCode == OpBeq) ? EQ : ~EQ;
            end
            StJump:    begin PcWrite = 1'b1; PCSrc = PcSrcJump; end
            StMdStart: begin MultStart = (Funct == FnMult); DivStart = (Funct == FnDiv); end
            StMdWb:    begin RegHighW = 1'b1; RegLowW = 1'b1; end
            StExcEpc:  begin ALUSrcB = SrcBFour; ALUCtrl = AluSub; EPC = 1'b1; end
            StExcRd:   begin IorD = IordExc; ExcpCtrl = code_q; end
            StExcLd:   MDR = 1'b1;
            StExcJmp:  begin PcWrite = 1'b1; PCSrc = PcSrcExc; end
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-stream bench: a trace model pushes per-cycle expected controls into a
// scoreboard queue that a negedge monitor drains against the controller outputs.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    localparam int MW = 2;

    typedef struct packed {
        logic [6:0] st;
        logic pcw; logic [1:0] iord; logic memctrl; logic irw; logic regw; logic [2:0] regdist;
        logic rega; logic regb; logic [1:0] srca; logic [2:0] srcb; logic [2:0] aluctrl;
        logic [2:0] pcsrc; logic epc; logic aluout; logic mdr; logic [2:0] memreg;
        logic divs; logic mults; logic hiw; logic low; logic [1:0] excp;
    } exp_t;

    typedef enum int {KAdd, KSub, KAnd, KMult, KDiv, KAddi, KLw, KSw, KBeq, KBne, KJ,
                      KBadOp, KBadFn} kind_e;

    logic Clock, Reset, b_rst, GT, EQ, LT, Overflow, DivZero, MDDone;
    logic [5:0] OPCode, Funct;
    logic [6:0] a_estado, b_estado;
    logic a_pcw, b_pcw, a_memctrl, b_memctrl, a_irw, b_irw, a_regw, b_regw, a_rega, b_rega;
    logic a_regb, b_regb, a_epc, b_epc, a_aluout, b_aluout, a_mdr, b_mdr, a_divs, b_divs;
    logic a_mults, b_mults, a_hiw, b_hiw, a_low, b_low;
    logic [1:0] a_iord, b_iord, a_srca, b_srca, a_excp, b_excp;
    logic [2:0] a_regdist, b_regdist, a_srcb, b_srcb, a_aluctrl, b_aluctrl;
    logic [2:0] a_pcsrc, b_pcsrc, a_memreg, b_memreg;
    exp_t act_a;

    exp_t  exp_q[$];
    string name_q[$];
    int    total, bad;
    kind_e cur_kind;
    logic [1:0] cur_code;
    int    inj_at;
    bit    aborted, rst_hold;

    assign act_a = {a_estado, a_pcw, a_iord, a_memctrl, a_irw, a_regw, a_regdist, a_rega, a_regb,
                    a_srca, a_srcb, a_aluctrl, a_pcsrc, a_epc, a_aluout, a_mdr, a_memreg,
                    a_divs, a_mults, a_hiw, a_low, a_excp};

    multicycle_control_unit #(.MEM_WAIT(MW), .STATE_W(7)) dut_a (
        .Clock(Clock), .Reset(Reset), .OPCode(OPCode), .Funct(Funct), .GT(GT), .EQ(EQ),
        .LT(LT), .Overflow(Overflow), .DivZero(DivZero), .MDDone(MDDone), .Estado(a_estado),
        .PcWrite(a_pcw), .IorD(a_iord), .MemCtrl(a_memctrl), .IrWrite(a_irw),
        .RegWrite(a_regw), .RegDist(a_regdist), .RegA(a_rega), .RegB(a_regb),
        .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUCtrl(a_aluctrl), .PCSrc(a_pcsrc), .EPC(a_epc),
        .ALUOut(a_aluout), .MDR(a_mdr), .MemReg(a_memreg), .DivStart(a_divs),
        .MultStart(a_mults), .RegHighW(a_hiw), .RegLowW(a_low), .ExcpCtrl(a_excp)
    );

    multicycle_control_unit #(.MEM_WAIT(0), .STATE_W(7)) dut_b (
        .Clock(Clock), .Reset(b_rst), .OPCode(OPCode), .Funct(Funct), .GT(GT), .EQ(EQ),
        .LT(LT), .Overflow(Overflow), .DivZero(DivZero), .MDDone(MDDone), .Estado(b_estado),
        .PcWrite(b_pcw), .IorD(b_iord), .MemCtrl(b_memctrl), .IrWrite(b_irw),
        .RegWrite(b_regw), .RegDist(b_regdist), .RegA(b_rega), .RegB(b_regb),
        .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUCtrl(b_aluctrl), .PCSrc(b_pcsrc), .EPC(b_epc),
        .ALUOut(b_aluout), .MDR(b_mdr), .MemReg(b_memreg), .DivStart(b_divs),
        .MultStart(b_mults), .RegHighW(b_hiw), .RegLowW(b_low), .ExcpCtrl(b_excp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Control values each step must present, straight from the state descriptions.
    function automatic exp_t model(input state_e s, input state_e ret, input logic eq);
        exp_t e;
        e = '0;
        e.st = s;
        case (s)
            StReset:  begin e.regw = 1; e.regdist = 3'b100; e.memreg = 3'b111; end
            StFetch:  begin e.srcb = 3'b001; e.aluctrl = 3'b001; end
            StMwait: begin
                if (ret == StLdmdr) e.iord = 2'b01;
                else if (ret == StExcLd) begin e.iord = 2'b10; e.excp = cur_code; end
                else begin e.srcb = 3'b001; e.aluctrl = 3'b001; end
            end
            StIrload: begin e.irw = 1; e.pcw = 1; end
            StDecode: begin
                e.rega = 1; e.regb = 1; e.srcb = 3'b011; e.aluctrl = 3'b001; e.aluout = 1;
            end
            StRAlu: begin
                e.srca = 2'b01; e.aluout = 1;
                e.aluctrl = (cur_kind == KSub) ? 3'b010 : (cur_kind == KAnd) ? 3'b011 : 3'b001;
            end
            StIAlu, StAddr: begin
                e.srca = 2'b01; e.srcb = 3'b010; e.aluctrl = 3'b001; e.aluout = 1;
            end
            StWb:     begin e.regw = 1; e.regdist = (cur_kind == KAddi) ? 3'b000 : 3'b001; end
            StLdreq:  e.iord = 2'b01;
            StLdmdr:  e.mdr = 1;
            StLdwb:   begin e.regw = 1; e.memreg = 3'b001; end
            StStore:  begin e.iord = 2'b01; e.memctrl = 1; end
            StBranch: begin
                e.srca = 2'b01; e.aluctrl = 3'b010; e.pcsrc = 3'b001;
                e.pcw = (cur_kind == KBeq) ? eq : !eq;
            end
            StJump:    begin e.pcw = 1; e.pcsrc = 3'b010; end
            StMdStart: begin e.mults = (cur_kind == KMult); e.divs = (cur_kind == KDiv); end
            StMdWb:    begin e.hiw = 1; e.low = 1; end
            StExcEpc:  begin e.srcb = 3'b001; e.aluctrl = 3'b010; e.epc = 1; end
            StExcRd:   begin e.iord = 2'b10; e.excp = cur_code; end
            StExcLd:   e.mdr = 1;
            StExcJmp:  begin e.pcw = 1; e.pcsrc = 3'b011; end
            default:   ;
        endcase
        return e;
    endfunction

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (act_a !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h", n, act_a, e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; -1 means draw that input at random.
    task automatic cyc(input state_e s, input state_e ret, input int ovf, input int eq,
                       input int dz, input int mdd);
        if (aborted) return;
        Reset = rst_hold;
        if (inj_at == 0) begin Reset = 1'b1; aborted = 1'b1; end
        if (inj_at >= 0) inj_at--;
        Overflow = (ovf < 0) ? 1'($urandom_range(0, 1)) : 1'(ovf);
        EQ       = (eq < 0) ? 1'($urandom_range(0, 1)) : 1'(eq);
        DivZero  = (dz < 0) ? 1'($urandom_range(0, 1)) : 1'(dz);
        MDDone   = (mdd < 0) ? 1'($urandom_range(0, 1)) : 1'(mdd);
        GT       = 1'($urandom_range(0, 1));
        LT       = 1'($urandom_range(0, 1));
        exp_q.push_back(model(s, ret, EQ));
        name_q.push_back(s.name());
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input state_e s);
        cyc(s, StIrload, -1, -1, -1, -1);
    endtask

    task automatic mem(input state_e ret);
        for (int i = 0; i < MW; i++) cyc(StMwait, ret, -1, -1, -1, -1);
    endtask

    task automatic exc(input logic [1:0] code);
        cur_code = code;
        step(StExcEpc);
        step(StExcRd);
        mem(StExcLd);
        step(StExcLd);
        step(StExcJmp);
    endtask

    task automatic run_instr(input kind_e k, input int op_force, input int ovf, input int eq,
                             input int dz, input int n, input int inj);
        logic [5:0] op, fn;
        fn = 6'($urandom_range(0, 63));
        op = OpRtype;
        case (k)
            KAdd:  fn = FnAdd;
            KSub:  fn = FnSub;
            KAnd:  fn = FnAnd;
            KMult: fn = FnMult;
            KDiv:  fn = FnDiv;
            KAddi: op = OpAddi;
            KLw:   op = OpLw;
            KSw:   op = OpSw;
            KBeq:  op = OpBeq;
            KBne:  op = OpBne;
            KJ:    op = OpJ;
            KBadOp: begin
                do op = 6'($urandom_range(1, 63));
                while (op inside {OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ});
            end
            default: begin
                do fn = 6'($urandom_range(0, 63));
                while (fn inside {FnAdd, FnSub, FnAnd, FnMult, FnDiv});
            end
        endcase
        if (op_force >= 0) op = 6'(op_force);
        OPCode = op;
        Funct = fn;
        cur_kind = k;
        aborted = 1'b0;
        inj_at = inj;
        step(StFetch);
        mem(StIrload);
        step(StIrload);
        step(StDecode);
        case (k)
            KAdd, KSub, KAnd: begin
                cyc(StRAlu, StIrload, ovf, -1, -1, -1);
                if (ovf != 0 && k != KAnd) exc(2'b01);
                else step(StWb);
            end
            KAddi: begin
                cyc(StIAlu, StIrload, ovf, -1, -1, -1);
                if (ovf != 0) exc(2'b01);
                else step(StWb);
            end
            KLw: begin step(StAddr); step(StLdreq); mem(StLdmdr); step(StLdmdr); step(StLdwb); end
            KSw: begin step(StAddr); step(StStore); end
            KBeq, KBne: cyc(StBranch, StIrload, -1, eq, -1, -1);
            KJ: step(StJump);
            KMult, KDiv: begin
                cyc(StMdStart, StIrload, -1, -1, dz, -1);
                if (k == KDiv && dz != 0) begin
                    exc(2'b10);
                end else begin
                    for (int i = 0; i < n; i++) cyc(StMdWait, StIrload, -1, -1, -1, 0);
                    cyc(StMdWait, StIrload, -1, -1, -1, 1);
                    step(StMdWb);
                end
            end
            default: exc(2'b00);
        endcase
        inj_at = -1;
        if (aborted) begin
            aborted = 1'b0;
            step(StReset);
        end
    endtask

    initial begin
        total = 0; bad = 0; inj_at = -1; aborted = 1'b0; rst_hold = 1'b1;
        Reset = 1'b1; b_rst = 1'b1; OPCode = OpRtype; Funct = FnAdd;
        GT = 0; EQ = 0; LT = 0; Overflow = 0; DivZero = 0; MDDone = 0;
        cur_kind = KAdd; cur_code = 2'b00;

        // Zero-wait instance: add completes in five cycles from FETCH.
        @(posedge Clock); #1;
        chk("mw0_reset", int'(b_estado), int'(StReset));
        b_rst = 1'b0;
        @(posedge Clock); #1;
        chk("mw0_fetch", int'(b_estado), int'(StFetch));
        @(posedge Clock); #1;
        chk("mw0_irload", int'(b_estado), int'(StIrload));
        chk("mw0_irwrite", int'(b_irw), 1);
        @(posedge Clock); #1;
        chk("mw0_decode", int'(b_estado), int'(StDecode));
        @(posedge Clock); #1;
        chk("mw0_r_alu", int'(b_estado), int'(StRAlu));
        @(posedge Clock); #1;
        chk("mw0_wb", int'(b_estado), int'(StWb));
        chk("mw0_wb_regwrite", int'(b_regw), 1);
        chk("mw0_wb_regdist", int'(b_regdist), 1);
        @(posedge Clock); #1;
        chk("mw0_back_to_fetch", int'(b_estado), int'(StFetch));
        b_rst = 1'b1;

        step(StReset);
        rst_hold = 1'b0;
        step(StReset);

        run_instr(KAdd, -1, 0, -1, 0, 0, -1);
        run_instr(KBeq, -1, 0, 1, 0, 0, -1);
        run_instr(KBeq, -1, 0, 0, 0, 0, -1);
        run_instr(KBne, -1, 0, 1, 0, 0, -1);
        run_instr(KBne, -1, 0, 0, 0, 0, -1);
        run_instr(KDiv, -1, 0, -1, 0, 10, -1);
        run_instr(KMult, -1, 0, -1, 0, 0, -1);
        run_instr(KBadOp, 6'h3F, 0, -1, 0, 0, -1);
        run_instr(KAdd, -1, 1, -1, 0, 0, -1);
        run_instr(KAnd, -1, 1, -1, 0, 0, -1);
        run_instr(KDiv, -1, 0, -1, 1, 0, -1);
        run_instr(KMult, -1, 0, -1, 0, 10, 8);
        run_instr(KLw, -1, 0, -1, 0, 0, 1);
        run_instr(KLw, -1, 0, -1, 0, 0, -1);

        for (int i = 0; i < 300; i++) begin
            run_instr(kind_e'($urandom_range(0, 12)), -1, int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 : 0,
                      int'($urandom_range(0, 6)),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : -1);
        end

        @(negedge Clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
